// File: rtl/btb.sv
// rtl/btb.sv - fully associative branch target buffer; optional macro BTB_EVICT_ON_NT_EN lets a not-taken hit evict its entry
module btb #(
  parameter int ENTRIES = 8,
  parameter int PTR_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IFpc,
  input  logic [31:0]      EXpc,
  input  logic [31:0]      BrNPC,
  input  logic             BranchE,
  input  logic [2:0]       BranchTypeE,
  output logic             BTBhit,
  output logic [31:0]      BTBtarget,
  output logic [PTR_W:0]   BTBcount
);

  // Table state: valid bits are reset, tag/target storage is not.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [29:0]        tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  // Lookup (IF side) results.
  logic               if_hit;
  logic [31:0]        if_target;

  // Update (EX side) decode.
  logic               upd_event;
  logic               ex_hit;
  logic [PTR_W-1:0]   ex_idx;
  logic               free_any;
  logic [PTR_W-1:0]   free_idx;

  // Storage write port.
  logic               wr_en;
  logic [PTR_W-1:0]   wr_idx;

  // Byte offset bits never take part in tag compare.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{IFpc[1:0], EXpc[1:0]};

  assign upd_event = (BranchTypeE != 3'd0);

  // IF lookup: tags are unique among valid entries, so OR-merging the matching target is exact.
  always_comb begin
    if_hit    = 1'b0;
    if_target = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == IFpc[31:2])) begin
        if_hit    = 1'b1;
        if_target = if_target | target_q[i];
      end
    end
  end

  assign BTBhit    = if_hit;
  assign BTBtarget = if_target;
  assign BTBcount  = count_q;

  // EX tag match: finds the resident entry for the resolving branch, if any.
  always_comb begin
    ex_hit = 1'b0;
    ex_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == EXpc[31:2])) begin
        ex_hit = 1'b1;
        ex_idx = PTR_W'(i);
      end
    end
  end

  // Lowest-index invalid entry; scanning downward lets the lowest index win.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = PTR_W'(i);
      end
    end
  end

  // Next-state for valid bits, replacement pointer and the write port.
  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = ex_idx;
    if (upd_event && BranchE) begin
      wr_en = 1'b1;
      if (ex_hit) begin
        // Taken hit: retarget in place; a stalled EX repeating this is idempotent.
        wr_idx = ex_idx;
      end else if (free_any) begin
        wr_idx           = free_idx;
        valid_d[free_idx] = 1'b1;
      end else begin
        // Full table: round-robin victim, pointer only moves on an eviction.
        wr_idx         = ptr_q;
        valid_d[ptr_q] = 1'b1;
        ptr_d          = ptr_q + PTR_W'(1);
      end
    end
`ifdef BTB_EVICT_ON_NT_EN
    else if (upd_event && ex_hit) begin
      valid_d[ex_idx] = 1'b0;
    end
`endif
  end

  // Population count of the next valid vector so the registered count tracks the table.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      count_d = count_d + (PTR_W+1)'(valid_d[i]);
    end
  end

  // Control state with asynchronous clear; an update racing reset is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Tag/target storage; contents only matter once the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      tag_q[wr_idx]    <= EXpc[31:2];
      target_q[wr_idx] <= BrNPC;
    end
  end

endmodule

// File: tb/tb_btb.sv
// tb/tb_btb.sv - self-checking scoreboard bench for btb
module tb_btb;

  localparam int ENTRIES = 8;
  localparam int PTR_W   = 3;

  logic          clk;
  logic          rst_n;
  logic [31:0]   IFpc;
  logic [31:0]   EXpc;
  logic [31:0]   BrNPC;
  logic          BranchE;
  logic [2:0]    BranchTypeE;
  logic          BTBhit;
  logic [31:0]   BTBtarget;
  logic [PTR_W:0] BTBcount;

  btb #(.ENTRIES(ENTRIES), .PTR_W(PTR_W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IFpc        (IFpc),
    .EXpc        (EXpc),
    .BrNPC       (BrNPC),
    .BranchE     (BranchE),
    .BranchTypeE (BranchTypeE),
    .BTBhit      (BTBhit),
    .BTBtarget   (BTBtarget),
    .BTBcount    (BTBcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  string phase = "init";

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s [%s] got=%h want=%h", tag, phase, obs, exp);
    end
  endtask

  // Reference table.
  logic        m_valid [ENTRIES];
  logic [29:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ptr;

  typedef struct packed {
    logic        hit;
    logic [31:0] tgt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  task automatic m_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_ptr = 0;
  endtask

  function automatic exp_t m_lookup(input logic [31:0] pc);
    exp_t e;
    e.hit = 1'b0;
    e.tgt = 32'h0;
    e.cnt = 32'h0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (m_valid[i]) e.cnt = e.cnt + 1;
      if (m_valid[i] && m_tag[i] == pc[31:2]) begin
        e.hit = 1'b1;
        e.tgt = m_tgt[i];
      end
    end
    return e;
  endfunction

  task automatic m_update(input logic [31:0] expc, input logic [31:0] npc, input logic br, input logic [2:0] bt);
    int hit_i;
    int free_i;
    hit_i  = -1;
    free_i = -1;
    if (bt == 3'd0) return;
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_tag[i] == expc[31:2]) hit_i = i;
    for (int i = 0; i < ENTRIES; i++)
      if (!m_valid[i] && free_i < 0) free_i = i;
    if (br) begin
      if (hit_i >= 0) begin
        m_tgt[hit_i] = npc;
      end else if (free_i >= 0) begin
        m_valid[free_i] = 1'b1; m_tag[free_i] = expc[31:2]; m_tgt[free_i] = npc;
      end else begin
        m_tag[m_ptr] = expc[31:2]; m_tgt[m_ptr] = npc;
        m_ptr = (m_ptr + 1) % ENTRIES;
      end
    end else begin
`ifdef BTB_EVICT_ON_NT_EN
      if (hit_i >= 0) m_valid[hit_i] = 1'b0;
`endif
    end
  endtask

  // Monitor: pop expected lookup results and compare mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      check_val("sb_hit", {31'h0, BTBhit}, {31'h0, sb_e.hit});
      check_val("sb_target", BTBtarget, sb_e.tgt);
      check_val("sb_count", {28'h0, BTBcount}, sb_e.cnt);
    end
  end

  // Valid entries must never share a tag.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        for (int j = i + 1; j < ENTRIES; j++)
          assert (!(u_dut.valid_q[i] && u_dut.valid_q[j] && u_dut.tag_q[i] == u_dut.tag_q[j]))
            else $error("duplicate tag in entries %0d and %0d", i, j);
    end
  end

  // One cycle: drive, push pre-edge expectation, wait through the edge, advance the model.
  task automatic step(input logic [31:0] ifpc, input logic [31:0] expc, input logic [31:0] npc,
                      input logic br, input logic [2:0] bt);
    IFpc = ifpc; EXpc = expc; BrNPC = npc; BranchE = br; BranchTypeE = bt;
    sb_q.push_back(m_lookup(ifpc));
    @(negedge clk);
    @(posedge clk);
    if (rst_n) m_update(expc, npc, br, bt);
    else m_reset();
    #1;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    step(ifpc, 32'h0, 32'h0, 1'b0, 3'd0);
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    IFpc = pc;
    #1;
    check_val({tag, "_hit"}, {31'h0, BTBhit}, {31'h0, hit});
    check_val({tag, "_tgt"}, BTBtarget, tgt);
  endtask

  initial begin
    rst_n = 1'b1; IFpc = 32'h100; EXpc = 0; BrNPC = 0; BranchE = 0; BranchTypeE = 0;
    m_reset();
    #1 rst_n = 1'b0;
    #2;
    phase = "reset";
    check_val("rst_hit", {31'h0, BTBhit}, 32'h0);
    check_val("rst_tgt", BTBtarget, 32'h0);
    check_val("rst_count", {28'h0, BTBcount}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    phase = "alloc";
    step(32'h40, 32'h40, 32'h80, 1'b1, 3'd1);
    idle(32'h40);
    probe("alloc", 32'h40, 1'b1, 32'h80);
    probe("alloc_lsb", 32'h42, 1'b1, 32'h80);
    check_val("alloc_count", {28'h0, BTBcount}, 32'd1);

    phase = "rewrite";
    repeat (3) step(32'h40, 32'h40, 32'hC0, 1'b1, 3'd1);
    probe("rewrite", 32'h40, 1'b1, 32'hC0);
    check_val("rewrite_count", {28'h0, BTBcount}, 32'd1);

    phase = "nonbranch";
    step(32'h200, 32'h200, 32'h300, 1'b1, 3'd0);
    probe("nonbranch", 32'h200, 1'b0, 32'h0);
    check_val("nonbranch_count", {28'h0, BTBcount}, 32'd1);

    phase = "nottaken";
    step(32'h40, 32'h40, 32'h0, 1'b0, 3'd2);
`ifdef BTB_EVICT_ON_NT_EN
    probe("nt", 32'h40, 1'b0, 32'h0);
    check_val("nt_count", {28'h0, BTBcount}, 32'd0);
`else
    probe("nt", 32'h40, 1'b1, 32'hC0);
    check_val("nt_count", {28'h0, BTBcount}, 32'd1);
`endif

    phase = "midreset";
    step(32'h40, 32'h44, 32'h88, 1'b1, 3'd1);
    IFpc = 32'h44; EXpc = 32'h48; BrNPC = 32'h99; BranchE = 1'b1; BranchTypeE = 3'd1;
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_hit", {31'h0, BTBhit}, 32'h0);
    check_val("midrst_count", {28'h0, BTBcount}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    idle(32'h48);
    probe("midrst_drop", 32'h48, 1'b0, 32'h0);
    check_val("midrst_after", {28'h0, BTBcount}, 32'h0);

    phase = "fill";
    for (int i = 0; i < ENTRIES; i++)
      step(32'h0, 32'(i * 4), 32'h1000 + 32'(i * 4), 1'b1, 3'd1);
    check_val("fill_count", {28'h0, BTBcount}, 32'd8);
    step(32'h0, 32'h20, 32'h1020, 1'b1, 3'd1);
    step(32'h4, 32'h24, 32'h1024, 1'b1, 3'd1);
    step(32'h8, 32'h8, 32'h1008, 1'b1, 3'd1);
    probe("wrap_0", 32'h0, 1'b0, 32'h0);
    probe("wrap_4", 32'h4, 1'b0, 32'h0);
    probe("wrap_8", 32'h8, 1'b1, 32'h1008);
    probe("wrap_20", 32'h20, 1'b1, 32'h1020);
    probe("wrap_24", 32'h24, 1'b1, 32'h1024);
    check_val("wrap_count", {28'h0, BTBcount}, 32'd8);
    step(32'h0, 32'h30, 32'h1030, 1'b1, 3'd1);
    probe("wrap_8_evicted", 32'h8, 1'b0, 32'h0);
    probe("wrap_c_kept", 32'hC, 1'b1, 32'h100C);

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ipc, epc, npc;
      ipc = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      epc = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      npc = $urandom;
      step(ipc, epc, npc, 1'($urandom), 3'($urandom_range(0, 3)));
    end
    idle(32'h0);

    check_val("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout [%s] got=running want=finished", phase);
    $fatal(1, "bench timeout");
  end

endmodule
